// File: rtl/pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// pio_in_edge_irq
//
// Input-only parallel I/O slave for the Avalon-MM system bus. External inputs
// are brought into the clk domain through a flop synchroniser. Each bit can
// latch an edge (rising, falling or either) into an edge-capture register.
// An interrupt mask gates the captured edges onto a level interrupt.
//
// Register map (32-bit words, unused upper bits read as 0):
//   0  data         synchronised in_port, read-only
//   1  direction    always reads 0, writes ignored (input-only block)
//   2  irqmask      read/write
//   3  edgecapture  read / write-to-clear
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset, clears every flop
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, only [DATA_WIDTH-1:0] is used
//   in_port     asynchronous external inputs
//   readdata    registered read data (1-cycle read latency)
//   irq         level interrupt, active high
//
// Bus semantics: a write is accepted in the cycle where chipselect=1 and
// write_n=0 and takes effect at the next rising edge; there is no wait state
// and no backpressure. Read data is registered every clock from the address
// presented at that edge, independent of chipselect, so a read issued at edge
// k returns its data right after edge k.
// -----------------------------------------------------------------------------
module pio_in_edge_irq #(
    parameter int DATA_WIDTH   = 8,  // 1..32
    parameter int EDGE_TYPE    = 0,  // 0 rising, 1 falling, 2 any
    parameter int SYNC_STAGES  = 2,  // 2..3
    parameter int BIT_CLEARING = 1   // 1 clear written-1 bits, 0 clear all
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_DIR      = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    // Elaboration-time parameter sanity.
    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
        $error("pio_in_edge_irq: DATA_WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("pio_in_edge_irq: SYNC_STAGES must be in 2..3");
    end
    if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
        $error("pio_in_edge_irq: EDGE_TYPE must be 0, 1 or 2");
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] sync_chain_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_val;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] edge_event;
    logic [DATA_WIDTH-1:0] edge_clr;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  wr;
    logic                  wr_irqmask;
    logic                  wr_edgecap;

    // Upper writedata bits are architecturally ignored.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign wr         = chipselect & ~write_n;
    assign wr_irqmask = wr && (address == ADDR_IRQMASK);
    assign wr_edgecap = wr && (address == ADDR_EDGECAP);

    // ------------------------------------------------------------------
    // Synchroniser: stage 0 samples the raw pins, the last stage is the
    // first value considered safe to use inside the clk domain.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain_q[s] <= '0;
            end
        end else begin
            sync_chain_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain_q[s] <= sync_chain_q[s-1];
            end
        end
    end

    assign sync_val = sync_chain_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge detection against the previous synchronised value
    // ------------------------------------------------------------------
    if (EDGE_TYPE == 0) begin : g_edge_rise
        assign edge_event = sync_val & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
        assign edge_event = ~sync_val & prev_q;
    end else begin : g_edge_any
        assign edge_event = sync_val ^ prev_q;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        edge_clr = '0;
        if (wr_edgecap) begin
            if (BIT_CLEARING != 0) begin
                edge_clr = writedata[DATA_WIDTH-1:0];
            end else begin
                edge_clr = '1;
            end
        end
    end

    // The event is OR-ed in after the clear so a new edge arriving in the
    // same cycle as a clear-write is never lost.
    assign edgecap_d = (edgecap_q & ~edge_clr) | edge_event;

    assign irqmask_d = wr_irqmask ? writedata[DATA_WIDTH-1:0] : irqmask_q;

    // Read mux samples the registers before this edge's update, giving the
    // documented one-cycle read latency.
    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA:    readdata_d[DATA_WIDTH-1:0] = sync_val;
            ADDR_DIR:     readdata_d = '0;
            ADDR_IRQMASK: readdata_d[DATA_WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[DATA_WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= sync_val;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: irq is decoded from flops only, so it cannot glitch on
    // in_port or bus activity.
    // ------------------------------------------------------------------
    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// -----------------------------------------------------------------------------
// tb_pio_in_edge_irq
//
// Three instances share the bus and input pins:
//   u0: DATA_WIDTH=8, rising edges,  SYNC_STAGES=2, BIT_CLEARING=1
//   u1: DATA_WIDTH=8, any edges,     SYNC_STAGES=2, BIT_CLEARING=0
//   u2: DATA_WIDTH=5, falling edges, SYNC_STAGES=3, BIT_CLEARING=1
// A reference model keeps a history of sampled input values and derives the
// synchronised value by looking SYNC_STAGES samples back; each clock it pushes
// the expected readdata triple into exp_q and a monitor on the falling edge
// pops and compares, also checking irq every cycle.
// -----------------------------------------------------------------------------
module tb_pio_in_edge_irq;

    localparam int NI = 3;
    localparam int DW_T [NI] = '{8, 8, 5};
    localparam int ET_T [NI] = '{0, 2, 1};
    localparam int SS_T [NI] = '{2, 2, 3};
    localparam int BC_T [NI] = '{1, 0, 1};

    // ---------------- clock / reset ----------------
    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [7:0]  in_port    = 8'd0;

    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.DATA_WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .BIT_CLEARING(1)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));

    pio_in_edge_irq #(.DATA_WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2), .BIT_CLEARING(0)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));

    pio_in_edge_irq #(.DATA_WIDTH(5), .EDGE_TYPE(1), .SYNC_STAGES(3), .BIT_CLEARING(1)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port[4:0]),
        .readdata(rd2), .irq(irq2));

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [95:0] exp_q [$];

    logic [31:0] ec_m   [NI];
    logic [31:0] mask_m [NI];
    logic        irq_m  [NI];
    logic [7:0]  hist   [5];   // hist[j] = in_port sampled j edges ago

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            ec_m[i]   = 32'd0;
            mask_m[i] = 32'd0;
            irq_m[i]  = 1'b0;
        end
        for (int j = 0; j < 5; j++) hist[j] = 8'd0;
        exp_q.delete();
    endtask

    // One rising edge: state before the edge produces readdata, then the
    // register state advances.
    task automatic model_step();
        logic [95:0] e;
        logic [31:0] wm, s, p, ev, clr, rd, ec_n, mk_n;
        bit          wr;
        for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
        wr = chipselect && !write_n;
        e  = '0;
        for (int i = 0; i < NI; i++) begin
            wm = 32'((64'd1 << DW_T[i]) - 64'd1);
            s  = {24'd0, hist[SS_T[i]]}     & wm;
            p  = {24'd0, hist[SS_T[i] + 1]} & wm;
            case (ET_T[i])
                0:       ev = s & ~p;
                1:       ev = ~s & p;
                default: ev = s ^ p;
            endcase
            ev &= wm;
            case (address)
                2'd0:    rd = s;
                2'd1:    rd = 32'd0;
                2'd2:    rd = mask_m[i];
                default: rd = ec_m[i];
            endcase
            e[i*32 +: 32] = rd;
            clr = 32'd0;
            if (wr && address == 2'd3) clr = (BC_T[i] != 0) ? writedata : 32'hFFFF_FFFF;
            clr &= wm;
            ec_n = (ec_m[i] & ~clr) | ev;
            mk_n = (wr && address == 2'd2) ? (writedata & wm) : mask_m[i];
            ec_m[i]   = ec_n;
            mask_m[i] = mk_n;
            irq_m[i]  = |(ec_n & mk_n);
        end
        exp_q.push_back(e);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else          model_step();
        end
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [95:0] e;
        forever begin
            @(negedge clk or negedge reset_n);
            if (!reset_n) begin
                #1;
                chk("rst_rd0", rd0, 32'd0);
                chk("rst_rd1", rd1, 32'd0);
                chk("rst_rd2", rd2, 32'd0);
                chk("rst_irq0", {31'd0, irq0}, 32'd0);
                chk("rst_irq1", {31'd0, irq1}, 32'd0);
                chk("rst_irq2", {31'd0, irq2}, 32'd0);
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rd0", rd0, e[31:0]);
                    chk("rd1", rd1, e[63:32]);
                    chk("rd2", rd2, e[95:64]);
                end
                chk("irq0", {31'd0, irq0}, {31'd0, irq_m[0]});
                chk("irq1", {31'd0, irq1}, {31'd0, irq_m[1]});
                chk("irq2", {31'd0, irq2}, {31'd0, irq_m[2]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        chipselect = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int op;
        // Reset with inputs already high at release.
        repeat (3) tick();
        in_port = 8'hA5;
        reset_n = 1'b1;
        repeat (6) bus_read(2'd0);
        bus_read(2'd3);
        bus_read(2'd2);

        // Rising capture on bit 0, masked interrupt, falling edge ignored by u0.
        in_port = 8'h00;
        bus_idle(4);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_write(2'd2, 32'h0000_0001);
        bus_idle(2);
        in_port[0] = 1'b1;
        bus_idle(2);
        in_port[0] = 1'b0;
        repeat (6) bus_read(2'd3);

        // Selective clear of edgecapture 0x03.
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port = 8'h03;
        bus_idle(5);
        bus_read(2'd3);
        bus_write(2'd3, 32'h0000_0001);
        repeat (3) bus_read(2'd3);

        // New edge on bit 0 in the same cycle as a clear of bit 0.
        in_port = 8'h00;
        bus_idle(5);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_idle(3);
        in_port[0] = 1'b1;
        bus_idle(2);
        bus_write(2'd3, 32'h0000_0001);
        repeat (3) bus_read(2'd3);

        // Toggle bit 3 in 3-cycle phases, clear-all write, ignored addresses.
        in_port = 8'h00;
        bus_idle(5);
        bus_write(2'd3, 32'h0000_0000);
        for (int t = 0; t < 4; t++) begin
            in_port[3] = ~in_port[3];
            bus_read(2'd3);
            bus_read(2'd3);
            bus_read(2'd3);
        end
        bus_idle(3);
        bus_write(2'd3, 32'h0000_0000);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) bus_read(2'(a));

        // Randomised traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            op = $urandom_range(0, 5);
            if (op < 3)       bus_read(2'($urandom_range(0, 3)));
            else if (op < 5)  bus_write(2'($urandom_range(0, 3)), $urandom);
            else              bus_idle(1);
        end

        // Fill edgecapture and irqmask, then reset mid-cycle.
        in_port = 8'h00;
        bus_idle(5);
        in_port = 8'hFF;
        bus_idle(5);
        in_port = 8'h00;
        bus_idle(5);
        in_port = 8'hFF;
        bus_idle(5);
        bus_write(2'd2, 32'h0000_00FF);
        bus_read(2'd3);
        bus_idle(2);
        @(posedge clk);
        #3;
        reset_n    = 1'b0;
        in_port    = 8'h00;
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) bus_read(2'(a));
        for (int a = 0; a < 4; a++) bus_read(2'(a));
        bus_idle(3);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
